// File: rtl/alu_pkg.sv
// Shared opcode encodings and default widths for the ALU issue stage.
package alu_pkg;
  localparam int ALU_DW     = 8;
  localparam int ALU_REG_AW = 3;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports plus a debug port, one sync write
// port, r0 hardwired to zero, synchronous clear.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DW     = ALU_DW,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DW-1:0]     rdata_a,
  output logic [DW-1:0]     rdata_b,
  output logic [DW-1:0]     dbg_data
);
  localparam int NREG = 2 ** REG_AW;

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a  == '0) ? '0 : mem[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : mem[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX/WB issue stage around an external combinational ALU.
// Build option ALU_ISSUE_FORWARD_EN: forward EX results instead of stalling one cycle.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DW     = ALU_DW,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_ra,
  input  logic [REG_AW-1:0] in_rb,
  input  logic              in_imm_en,
  input  logic [DW-1:0]     in_imm,
  output logic [DW-1:0]     alu_src_a,
  output logic [DW-1:0]     alu_src_b,
  output logic [2:0]        alu_c,
  input  logic [DW-1:0]     alu_data_out,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DW-1:0]     wb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DW-1:0]     dbg_data
);
  logic              vld_p1, vld_p2;
  logic [2:0]        op_p1;
  logic [REG_AW-1:0] rd_p1, rd_p2;
  logic [DW-1:0]     a_p1, b_p1, data_p2;
  logic [DW-1:0]     rf_a, rf_b, opnd_a, opnd_b;
  logic              ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b, accept;

  alu_regfile #(.DW(DW), .REG_AW(REG_AW)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (vld_p2),
    .waddr    (rd_p2),
    .wdata    (data_p2),
    .raddr_a  (in_ra),
    .raddr_b  (in_rb),
    .dbg_addr (dbg_addr),
    .rdata_a  (rf_a),
    .rdata_b  (rf_b),
    .dbg_data (dbg_data)
  );

  // ID stage: hazard detection and operand selection
  assign ex_hit_a = vld_p1 && (rd_p1 == in_ra) && (in_ra != '0);
  assign ex_hit_b = vld_p1 && (rd_p1 == in_rb) && (in_rb != '0) && !in_imm_en;
  assign wb_hit_a = vld_p2 && (rd_p2 == in_ra);
  assign wb_hit_b = vld_p2 && (rd_p2 == in_rb);

`ifdef ALU_ISSUE_FORWARD_EN
  assign in_ready = 1'b1;
`else
  // A stalled instruction finds its producer in WB on the retry cycle.
  assign in_ready = !(in_valid && (ex_hit_a || ex_hit_b));
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    opnd_a = rf_a;
    if (in_ra == '0) opnd_a = '0;
`ifdef ALU_ISSUE_FORWARD_EN
    else if (ex_hit_a) opnd_a = alu_data_out;
`endif
    else if (wb_hit_a) opnd_a = data_p2;
  end

  always_comb begin
    opnd_b = rf_b;
    if (in_imm_en) opnd_b = in_imm;
    else if (in_rb == '0) opnd_b = '0;
`ifdef ALU_ISSUE_FORWARD_EN
    else if (ex_hit_b) opnd_b = alu_data_out;
`endif
    else if (wb_hit_b) opnd_b = data_p2;
  end

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      op_p1  <= '0;
      rd_p1  <= '0;
      a_p1   <= '0;
      b_p1   <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        op_p1 <= in_op;
        rd_p1 <= in_rd;
        a_p1  <= opnd_a;
        b_p1  <= opnd_b;
      end
    end
  end

  assign alu_src_a = a_p1;
  assign alu_src_b = b_p1;
  assign alu_c     = op_p1;

  // EX -> WB boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      rd_p2   <= '0;
      data_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      rd_p2   <= rd_p1;
      data_p2 <= alu_data_out;
    end
  end

  assign wb_valid = vld_p2;
  assign wb_rd    = rd_p2;
  assign wb_data  = data_p2;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU and an
// in-order architectural register model; honours ALU_ISSUE_FORWARD_EN.
`timescale 1ns/1ps
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = '0;
  logic [2:0] in_rd = '0, in_ra = '0, in_rb = '0;
  logic       in_imm_en = 1'b0;
  logic [7:0] in_imm = '0;
  logic [7:0] alu_src_a, alu_src_b, alu_data_out;
  logic [2:0] alu_c;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stalls = 0;
  int mrf [8];
  int exp_rd [$];
  int exp_data [$];
  int wb_cyc [$];

  always #5 clk = ~clk;

  alu_issue_stage #(.DW(8), .REG_AW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rd        (in_rd),
    .in_ra        (in_ra),
    .in_rb        (in_rb),
    .in_imm_en    (in_imm_en),
    .in_imm       (in_imm),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_c        (alu_c),
    .alu_data_out (alu_data_out),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Combinational ALU the stage drives
  always_comb begin
    alu_data_out = alu_src_a;
    case (alu_c)
      OP_ADD:  alu_data_out = alu_src_a + alu_src_b;
      OP_SUB:  alu_data_out = alu_src_a - alu_src_b;
      OP_AND:  alu_data_out = alu_src_a & alu_src_b;
      OP_OR:   alu_data_out = alu_src_a | alu_src_b;
      OP_XOR:  alu_data_out = alu_src_a ^ alu_src_b;
      default: alu_data_out = alu_src_a;
    endcase
  end

  function automatic int ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      1:       r = a + b;
      2:       r = a - b + 256;
      3:       r = a & b;
      4:       r = a | b;
      5:       r = a ^ b;
      default: r = a;
    endcase
    return r % 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (exp_rd.size() == 0) begin
      chk("wb_spurious", {31'd0, wb_valid}, 32'd0);
    end else if (wb_valid === 1'b1) begin
      chk("wb_rd", {29'd0, wb_rd}, exp_rd.pop_front());
      chk("wb_data", {24'd0, wb_data}, exp_data.pop_front());
      wb_cyc.push_back(cyc);
    end
  endtask

  task automatic issue(input int op, input int rd, input int ra, input int rb,
                       input int ie, input int imm);
    int waits;
    int b;
    int res;
    in_valid  = 1'b1;
    in_op     = 3'(op);
    in_rd     = 3'(rd);
    in_ra     = 3'(ra);
    in_rb     = 3'(rb);
    in_imm_en = (ie != 0);
    in_imm    = 8'(imm);
    #1;
    waits = 0;
    while (in_ready !== 1'b1 && waits < 4) begin
      stalls++;
      waits++;
      cycle();
      #1;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready === 1'b1) begin
      b   = (ie != 0) ? imm : mrf[rb];
      res = ref_alu(op, mrf[ra], b);
      exp_rd.push_back(rd);
      exp_data.push_back(res);
      if (rd != 0) mrf[rd] = res;
    end
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) cycle();
    chk("wb_missing", exp_rd.size(), 32'd0);
  endtask

  task automatic check_reg(input int addr, input int exp);
    dbg_addr = 3'(addr);
    #0.1;
    chk($sformatf("dbg_r%0d", addr), {24'd0, dbg_data}, exp);
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < 8; i++) check_reg(i, mrf[i]);
  endtask

  int exp_stall;

  initial begin
    for (int i = 0; i < 8; i++) mrf[i] = 0;
`ifdef ALU_ISSUE_FORWARD_EN
    exp_stall = 0;
`else
    exp_stall = 1;
`endif

    // Reset state
    repeat (2) cycle();
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", {24'd0, wb_data}, 32'd0);
    chk("rst_src_a", {24'd0, alu_src_a}, 32'd0);
    chk("rst_src_b", {24'd0, alu_src_b}, 32'd0);
    chk("rst_alu_c", {29'd0, alu_c}, 32'd0);
    rst = 1'b0;
    #0.1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_all_regs();

    // 1: back-to-back immediate adds from r0
    wb_cyc.delete();
    issue(1, 1, 0, 0, 1, 5);
    issue(1, 2, 0, 0, 1, 3);
    drain(4);
    chk("t1_consecutive", wb_cyc[1] - wb_cyc[0], 32'd1);
    check_reg(1, 5);
    check_reg(2, 3);

    // 2: register-register ops, including a wrapping subtract
    issue(2, 3, 1, 2, 0, 0);
    issue(5, 4, 1, 2, 0, 0);
    issue(3, 5, 1, 2, 0, 0);
    issue(2, 6, 2, 1, 0, 0);
    drain(4);
    check_reg(3, 2);
    check_reg(4, 6);
    check_reg(5, 1);
    check_reg(6, 254);

    // 3: read-after-write on back-to-back instructions
    stalls = 0;
    issue(1, 4, 0, 0, 1, 200);
    issue(1, 4, 4, 0, 1, 100);
    drain(4);
    chk("t3_stalls", stalls, exp_stall);
    check_reg(4, 44);

    // 4: writes to r0 show on WB but never land; r0 never hazards
    stalls = 0;
    issue(1, 0, 0, 0, 1, 9);
    issue(1, 6, 0, 0, 0, 0);
    drain(4);
    chk("t4_stalls", stalls, 32'd0);
    check_reg(0, 0);
    check_reg(6, 0);

    // 5: undefined opcodes pass operand A
    issue(6, 7, 1, 2, 0, 0);
    issue(0, 3, 1, 2, 0, 0);
    drain(4);
    check_reg(7, 5);
    check_reg(3, 5);

    // 6: reset while EX and WB are both occupied
    issue(1, 1, 0, 0, 1, 7);
    issue(1, 2, 0, 0, 1, 8);
    chk("t6_ex_busy_src_a", {24'd0, alu_src_a}, 32'd0);
    exp_rd.delete();
    exp_data.delete();
    for (int i = 0; i < 8; i++) mrf[i] = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_all_regs();
    cycle();
    chk("t6_wb_valid_after", {31'd0, wb_valid}, 32'd0);
    check_all_regs();

    // Randomised instruction stream against the architectural model
    for (int n = 0; n < 120; n++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) cycle();
    end
    drain(5);
    check_all_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
